// File: rtl/lstm_init_sequencer_if.sv
// Valid/ready load port from the initial-value sequencer into the LSTM cell's
// state and bias registers.
interface lstm_init_sequencer_if #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 64
) ();
  logic              ld_valid;
  logic              ld_ready;
  logic [IDX_W-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last,
    output ld_ready
  );
endinterface

// File: rtl/lstm_init_sequencer.sv
// Walks the initial-value ROM from index 0 to N_ENTRIES-1 and hands each word,
// with its index, to the LSTM cell over a valid/ready load port.
module lstm_init_sequencer #(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = 3,
  parameter int DATA_W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic [IDX_W-1:0]      rom_index,
  input  logic [DATA_W-1:0]     rom_data,
  lstm_init_sequencer_if.master ld,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  index_nxt;
  logic [IDX_W-1:0]  addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              valid_nxt;
  logic              last_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rom_index   <= '0;
      ld.ld_valid <= 1'b0;
      ld.ld_addr  <= '0;
      ld.ld_data  <= '0;
      ld.ld_last  <= 1'b0;
    end else begin
      state       <= state_nxt;
      rom_index   <= index_nxt;
      ld.ld_valid <= valid_nxt;
      ld.ld_addr  <= addr_nxt;
      ld.ld_data  <= data_nxt;
      ld.ld_last  <= last_nxt;
    end
  end

  // Abort overrides everything outside IDLE; in IDLE it only suppresses start.
  always_comb begin
    state_nxt = state;
    index_nxt = rom_index;
    valid_nxt = ld.ld_valid;
    addr_nxt  = ld.ld_addr;
    data_nxt  = ld.ld_data;
    last_nxt  = ld.ld_last;

    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
      index_nxt = '0;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state_nxt = S_FETCH;
            index_nxt = '0;
          end
        end
        S_FETCH: begin
          data_nxt  = rom_data;
          addr_nxt  = rom_index;
          last_nxt  = (rom_index == LAST_IDX);
          valid_nxt = 1'b1;
          state_nxt = S_PRESENT;
        end
        S_PRESENT: begin
          if (ld.ld_ready) begin
            valid_nxt = 1'b0;
            if (ld.ld_last) begin
              state_nxt = S_DONE;
            end else begin
              index_nxt = rom_index + IDX_W'(1);
              state_nxt = S_FETCH;
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          index_nxt = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          index_nxt = '0;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
